anita3_digitize_clear_ctrl: RTL and testbench
=============================================

Name: anita3_digitize_clear_ctrl

Overview:
- Consumer side of the buffer-manager digitize/clear interface. Accepts digitize requests (pulse plus 2-bit buffer index) and queues them in arrival order.
- Runs a request/done handshake with the readout path for each buffer, then returns the buffer to the manager with a one-cycle clear pulse.
- Sits between the trigger buffer manager and the SURF readout sequencer, in the 250 MHz domain.

Parameters:
- TIMEOUT_CYCLES, 65535: max cycles readout_req_o stays high without readout_done_i before a forced clear.
- HOLDOFF_CYCLES, 4: idle cycles after each clear before the next request is issued.
- NBUF, 4: number of hold buffers. Fixed by the 2-bit index; other values are unsupported.

Ports:
- clk250_i  in  1  system clock, 250 MHz.
- rst_i  in  1  synchronous, active-high reset.
- digitize_i  in  1  one-cycle digitize request from the buffer manager.
- digitize_buffer_i  in  2  buffer index, valid with digitize_i.
- readout_req_o  out  1  level request to readout; held until done or timeout.
- readout_buffer_o  out  2  buffer being read; stable while readout_req_o is high.
- readout_done_i  in  1  one-cycle completion from readout.
- clear_o  out  1  one-cycle clear pulse to the buffer manager.
- clear_buffer_o  out  2  buffer index, valid with clear_o.
- busy_o  out  1  high when the queue is non-empty or the FSM is not IDLE.
- pending_o  out  3  queue occupancy, 0..4.
- timeout_count_o  out  8  saturating count of forced clears.
- dup_err_o  out  1  sticky: digitize_i for a buffer already pending or in service.

Behaviour:
- Reset (rst_i sampled high at a clock edge): all outputs 0; queue emptied; pending mask cleared; FSM to IDLE; counters cleared; dup_err_o cleared.
- Reset mid-operation: no clear_o is issued for the abandoned buffer. Upstream is reset by the same rst_i.
- Queue: 4-entry FIFO of indices plus a 4-bit pending mask.
  - The mask bit is set on accept and cleared in the cycle clear_o fires.
  - Indices are unique while pending, so the queue cannot overflow.
- Accept: digitize_i high and mask[digitize_buffer_i]=0 -> push and set the mask bit at that edge.
- Duplicate: digitize_i high and the mask bit already set -> request dropped, dup_err_o set, no other effect.
- Simultaneous push and pop in one cycle are both honoured; pending_o reflects the net change.
- FSM states:
  - IDLE:
    - If the queue is non-empty: pop the head, load readout_buffer_o, assert readout_req_o at the next edge, go to REQ.
    - Latency: digitize_i sampled at edge N with an empty queue in IDLE -> readout_req_o high after edge N+2.
  - REQ:
    - readout_req_o=1; the timeout counter increments each cycle.
    - readout_done_i=1 -> go to CLEAR.
    - Counter reaches TIMEOUT_CYCLES-1 without done -> increment timeout_count_o (saturates at 255), go to CLEAR.
    - Done and timeout in the same cycle: counts as done, no timeout increment.
  - CLEAR:
    - readout_req_o=0; clear_o=1 and clear_buffer_o=readout_buffer_o for exactly one cycle; mask bit cleared.
    - Go to HOLDOFF, or to IDLE if HOLDOFF_CYCLES=0.
  - HOLDOFF: wait HOLDOFF_CYCLES cycles, then IDLE.
- readout_done_i outside REQ is ignored.
- A digitize_i for the buffer currently in CLEAR, in the same cycle as clear_o: treated as a duplicate, because the mask clears after the compare.
- clear_buffer_o holds its last value when clear_o=0; the verifier checks it only when clear_o=1.

Decomposition:
- Shared package (anita3_pkg): BUF_IDX_W=2, NBUF=4, FSM state enum.
- One sub-module, anita3_idx_fifo: 4x2-bit FIFO with count, push, pop and empty. It serves the arrival-order queue.
- The FSM, mask, timeout counter and statistics stay in the top module.

Test Plan:
- Single: digitize buffer 1 at edge N -> req_o=1 and readout_buffer_o=1 at N+2; done at N+10 -> clear_o=1 and clear_buffer_o=1 at N+11 for one cycle; next request no earlier than N+12+HOLDOFF_CYCLES.
- Back-to-back: digitize 0,2,3,1 on consecutive cycles -> pending_o peaks at 3; req issued in order 0,2,3,1; four clears in the same order.
- Duplicate: digitize 2 twice while 2 is pending -> dup_err_o=1; exactly one clear for 2; pending_o unaffected by the second request.
- Timeout: TIMEOUT_CYCLES=16, no done -> clear_o 16 cycles after req rise; timeout_count_o=1. Repeat 300 times -> timeout_count_o holds at 255.
- Edge cases: done and timeout in the same cycle -> timeout_count_o unchanged. Simultaneous push with IDLE pop of a different buffer -> pending_o correct.
- Reset mid-REQ: rst_i asserted for 1 cycle -> req_o=0, pending_o=0, no clear_o; a fresh digitize is then serviced normally.

Source files
------------

// File: rtl/anita3_pkg.sv
// Shared types and constants for the ANITA-3 digitize/clear controller.
// Buffer indices are 2 bits wide, so exactly four hold buffers exist.
package anita3_pkg;

  localparam int BUF_IDX_W = 2;
  localparam int NBUF      = 4;

  typedef logic [BUF_IDX_W-1:0] buf_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_CLEAR,
    ST_HOLDOFF
  } state_e;

endpackage

// File: rtl/anita3_idx_fifo.sv
// Four-entry FIFO of buffer indices holding digitize requests in arrival order.
// A simultaneous push and pop are both honoured.
module anita3_idx_fifo
  import anita3_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  buf_idx_t   push_idx_i,
  input  logic       pop_i,
  output buf_idx_t   head_o,
  output logic [2:0] count_o,
  output logic       empty_o
);

  buf_idx_t            mem_q [NBUF];
  logic [BUF_IDX_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]          count_q, count_d;
  logic                push_ok, pop_ok;

  assign push_ok = push_i && (count_q != 3'(NBUF));
  assign pop_ok  = pop_i  && (count_q != 3'd0);
  assign count_d = count_q + {2'b00, push_ok} - {2'b00, pop_ok};

  // NOTE: the storage array is deliberately not reset; validity is defined
  // by the pointers and count alone, which keeps the array a plain RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_idx_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 3'd0);

endmodule

// File: rtl/anita3_digitize_clear_ctrl.sv
// Queues digitize requests, runs the readout request/done handshake per buffer
// and hands each buffer back to the manager with a one-cycle clear pulse.
module anita3_digitize_clear_ctrl
  import anita3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic       clk250_i,
  input  logic       rst_i,
  input  logic       digitize_i,
  input  buf_idx_t   digitize_buffer_i,
  output logic       readout_req_o,
  output buf_idx_t   readout_buffer_o,
  input  logic       readout_done_i,
  output logic       clear_o,
  output buf_idx_t   clear_buffer_o,
  output logic       busy_o,
  output logic [2:0] pending_o,
  output logic [7:0] timeout_count_o,
  output logic       dup_err_o
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  // The forced clear fires on the edge where the counter's next value reaches
  // TIMEOUT_CYCLES-1, so the request never stays up longer than TIMEOUT_CYCLES.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

  state_e          state_q;
  logic            req_q, clear_q, dup_err_q;
  buf_idx_t        buf_q, clear_buf_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [HO_W-1:0] hold_cnt_q;
  logic [7:0]      timeout_count_q;
  logic [NBUF-1:0] mask_q, mask_d;

  logic       accept, dup, pop, fifo_empty;
  buf_idx_t   fifo_head;
  logic [2:0] fifo_count;

  assign accept = digitize_i && !mask_q[digitize_buffer_i];
  assign dup    = digitize_i &&  mask_q[digitize_buffer_i];
  assign pop    = (state_q == ST_IDLE) && !fifo_empty;

  anita3_idx_fifo u_fifo (
    .clk_i      (clk250_i),
    .rst_i      (rst_i),
    .push_i     (accept),
    .push_idx_i (digitize_buffer_i),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty)
  );

  // Mask clears at the end of the clear_o cycle, so a same-cycle digitize of
  // that buffer still compares against the set bit and counts as a duplicate.
  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    mask_d = mask_q;
    if (clear_q) mask_d[clear_buf_q] = 1'b0;
    if (accept)  mask_d[digitize_buffer_i] = 1'b1;
  end

  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      mask_q    <= '0;
      dup_err_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      if (dup) dup_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      req_q           <= 1'b0;
      clear_q         <= 1'b0;
      buf_q           <= '0;
      clear_buf_q     <= '0;
      to_cnt_q        <= '0;
      hold_cnt_q      <= '0;
      timeout_count_q <= '0;
    end else begin
      clear_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            buf_q   <= fifo_head;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          req_q    <= 1'b1;
          to_cnt_q <= '0;
          state_q  <= ST_REQ;
        end
        ST_REQ: begin
          if (readout_done_i) begin
            req_q   <= 1'b0;
            state_q <= ST_CLEAR;
          end else if (to_cnt_q == TO_LAST) begin
            req_q   <= 1'b0;
            state_q <= ST_CLEAR;
            if (timeout_count_q != 8'hFF) timeout_count_q <= timeout_count_q + 8'd1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ST_CLEAR: begin
          clear_q     <= 1'b1;
          clear_buf_q <= buf_q;
          hold_cnt_q  <= '0;
          state_q     <= (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          if (hold_cnt_q == HO_LAST) state_q <= ST_IDLE;
          else                       hold_cnt_q <= hold_cnt_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign readout_req_o    = req_q;
  assign readout_buffer_o = buf_q;
  assign clear_o          = clear_q;
  assign clear_buffer_o   = clear_buf_q;
  assign busy_o           = !fifo_empty || (state_q != ST_IDLE);
  assign pending_o        = fifo_count;
  assign timeout_count_o  = timeout_count_q;
  assign dup_err_o        = dup_err_q;

endmodule

// File: tb/tb_anita3_digitize_clear_ctrl.sv
// Bench for the digitize/clear controller: directed stimulus, with request and
// clear ordering checked by a scoreboard monitor on the falling clock edge.
module tb_anita3_digitize_clear_ctrl;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int HOLDOFF_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       digitize = 1'b0;
  logic [1:0] digitize_buffer = 2'd0;
  logic       done = 1'b0;
  logic       req, clear, busy, dup_err;
  logic [1:0] req_buf, clear_buf;
  logic [2:0] pending;
  logic [7:0] timeout_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_req[$];
  int exp_clear[$];

  always #2 clk = ~clk;

  anita3_digitize_clear_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) dut (
    .clk250_i         (clk),
    .rst_i            (rst),
    .digitize_i       (digitize),
    .digitize_buffer_i(digitize_buffer),
    .readout_req_o    (req),
    .readout_buffer_o (req_buf),
    .readout_done_i   (done),
    .clear_o          (clear),
    .clear_buffer_o   (clear_buf),
    .busy_o           (busy),
    .pending_o        (pending),
    .timeout_count_o  (timeout_count),
    .dup_err_o        (dup_err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx);
    exp_req.push_back(idx);
    exp_clear.push_back(idx);
    digitize        = 1'b1;
    digitize_buffer = 2'(idx);
    step();
    digitize        = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req && n < 40) begin
      step();
      n++;
    end
    check("wait_req", int'(req), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 80) begin
      step();
      n++;
    end
    check("wait_idle", int'(busy), 0);
  endtask

  // delay < 0 means readout never answers and the timeout must fire.
  task automatic run_one(input int idx, input int delay);
    issue(idx);
    wait_req();
    if (delay >= 0) begin
      repeat (delay) step();
      pulse_done();
    end
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_req.delete();
    exp_clear.delete();
  endtask

  // Scoreboard monitor: every request rise and every clear pulse is matched
  // against the next expected buffer index.
  initial begin
    logic prev_req   = 1'b0;
    logic prev_clear = 1'b0;
    logic [1:0] prev_buf = 2'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req   = 1'b0;
        prev_clear = 1'b0;
      end else begin
        if (req && !prev_req) begin
          if (exp_req.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_req: got buffer %0d, expected none", req_buf);
          end else check("req_order", int'(req_buf), exp_req.pop_front());
        end
        if (req && prev_req && req_buf != prev_buf)
          check("req_buf_stable", int'(req_buf), int'(prev_buf));
        if (clear) begin
          if (prev_clear) check("clear_width", 2, 1);
          if (exp_clear.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_clear: got buffer %0d, expected none", clear_buf);
          end else check("clear_order", int'(clear_buf), exp_clear.pop_front());
        end
        prev_req   = req;
        prev_clear = clear;
        prev_buf   = req_buf;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_req",     int'(req), 0);
    check("rst_clear",   int'(clear), 0);
    check("rst_busy",    int'(busy), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_tcount",  int'(timeout_count), 0);
    check("rst_dup",     int'(dup_err), 0);

    // Single buffer: latency N+2 to request, N+11 clear, holdoff before next.
    issue(1);                                   // edge N
    check("single_pend", int'(pending), 1);
    check("single_req_n0", int'(req), 0);
    step();                                     // N+1
    check("single_req_n1", int'(req), 0);
    check("single_pend_pop", int'(pending), 0);
    step();                                     // N+2
    check("single_req_n2", int'(req), 1);
    check("single_buf_n2", int'(req_buf), 1);
    repeat (7) step();                          // N+9
    pulse_done();                               // N+10
    check("single_req_drop", int'(req), 0);
    check("single_clear_n10", int'(clear), 0);
    step();                                     // N+11
    check("single_clear_n11", int'(clear), 1);
    check("single_clear_buf", int'(clear_buf), 1);
    issue(3);                                   // N+12
    check("single_clear_n12", int'(clear), 0);
    repeat (4) step();                          // N+16
    check("holdoff_req_n16", int'(req), 0);
    step();                                     // N+17
    check("holdoff_req_n17", int'(req), 1);
    check("holdoff_buf_n17", int'(req_buf), 3);
    pulse_done();
    wait_idle();

    // Back-to-back 0,2,3,1 including a push in the same cycle as an IDLE pop.
    issue(0); check("b2b_pend0", int'(pending), 1);
    issue(2); check("b2b_pend1", int'(pending), 1);
    issue(3); check("b2b_pend2", int'(pending), 2);
    issue(1); check("b2b_pend3", int'(pending), 3);
    for (int i = 0; i < 4; i++) begin
      wait_req();
      repeat (2) step();
      pulse_done();
    end
    wait_idle();

    // Duplicate while pending, then again while in service.
    do_reset();
    issue(2);
    check("dup_pend_first", int'(pending), 1);
    digitize = 1'b1; digitize_buffer = 2'd2;
    step();
    digitize = 1'b0;
    check("dup_flag", int'(dup_err), 1);
    check("dup_pend", int'(pending), 0);
    wait_req();
    digitize = 1'b1; digitize_buffer = 2'd2;
    step();
    digitize = 1'b0;
    check("dup_inreq_pend", int'(pending), 0);
    pulse_done();
    wait_idle();

    // Digitize of the buffer being cleared, in the clear_o cycle, is a duplicate.
    do_reset();
    check("clrdup_rst_flag", int'(dup_err), 0);
    issue(2);
    wait_req();
    pulse_done();
    step();
    check("clrdup_clear", int'(clear), 1);
    digitize = 1'b1; digitize_buffer = 2'd2;
    step();
    digitize = 1'b0;
    check("clrdup_flag", int'(dup_err), 1);
    check("clrdup_pend", int'(pending), 0);
    wait_idle();
    run_one(2, 1);

    // Timeout: clear 16 cycles after request rise, count increments.
    do_reset();
    issue(0);
    wait_req();
    begin
      int k = 0;
      while (!clear && k < 40) begin
        step();
        k++;
      end
      check("timeout_latency", k, TIMEOUT_CYCLES);
    end
    wait_idle();
    check("timeout_count1", int'(timeout_count), 1);
    run_one(1, 14);
    check("done_at_timeout", int'(timeout_count), 1);
    run_one(2, 15);
    check("done_after_timeout", int'(timeout_count), 2);
    for (int i = 0; i < 300; i++) run_one(i % 4, -1);
    check("timeout_saturate", int'(timeout_count), 255);

    // Reset during REQ: no clear for the abandoned buffer.
    issue(3);
    wait_req();
    step();
    do_reset();
    check("midrst_req", int'(req), 0);
    check("midrst_pend", int'(pending), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_tcount", int'(timeout_count), 0);
    repeat (10) step();
    run_one(1, 3);

    check("exp_req_drained", exp_req.size(), 0);
    check("exp_clear_drained", exp_clear.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
